// File: rtl/level_selector.sv
// level_selector
//
// Picks a game level from the signs of N_LEV lever channels and locks it once
// the derived code has held steady for STABLE_CYCLES consecutive clock edges.
// The locked level is kept until game_over is seen. A new selection needs
// another start_game.
//
// Ports
//   clock        system clock; all state changes happen on its rising edge
//   reset        asynchronous, active-high; returns to IDLE and clears level
//   levers       N_LEV signed samples, channel i at [i*DATA_W +: DATA_W]
//   start_game   level-sensitive request to begin a selection (used in IDLE only)
//   game_over    releases the lock or abandons a selection in progress
//   level        locked level code, registered; channel 0 drives the MSB
//   level_valid  high only while LOCKED
//   busy         high only while SETTLE
//
// Optional feature
//   LEVEL_DEADZONE_EN  when defined, a channel whose magnitude is below
//                      DEADZONE counts as ambiguous. An ambiguous sample
//                      clears the stability counter and stops a lock. When the
//                      macro is not defined, only the sign bits are used.

module level_selector #(
  parameter int N_LEV         = 2,
  parameter int DATA_W        = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int DEADZONE      = 2048
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_LEV*DATA_W-1:0]   levers,
  input  logic                      start_game,
  input  logic                      game_over,
  output logic [N_LEV-1:0]          level,
  output logic                      level_valid,
  output logic                      busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N_LEV-1:0]   ref_code;
  logic [N_LEV-1:0]   ref_next;
  logic [N_LEV-1:0]   level_next;
  logic [N_LEV-1:0]   candidate;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               ambiguous;

  // Candidate code: a non-negative channel sets its bit. Channel 0 maps to the MSB.
  for (genvar gi = 0; gi < N_LEV; gi++) begin : g_cand
    assign candidate[N_LEV-1-gi] = ~levers[gi*DATA_W + DATA_W - 1];
  end

`ifdef LEVEL_DEADZONE_EN
  localparam logic [DATA_W:0] DZ = (DATA_W+1)'(DEADZONE);
  logic [N_LEV-1:0] amb_bits;

  // The magnitude uses one extra bit, so the most negative sample
  // (e.g. -32768) gives its true size instead of wrapping back to itself.
  for (genvar gi = 0; gi < N_LEV; gi++) begin : g_dz
    logic [DATA_W:0] ext;
    logic [DATA_W:0] mag;
    assign ext          = {levers[gi*DATA_W + DATA_W - 1], levers[gi*DATA_W +: DATA_W]};
    assign mag          = ext[DATA_W] ? (~ext + 1'b1) : ext;
    assign amb_bits[gi] = (mag < DZ);
  end
  assign ambiguous = |amb_bits;
`else
  // Only the sign bits are used. The lower sample bits and DEADZONE go into a
  // sink net so they do not show up as dangling.
  logic unused_bits;
  assign unused_bits = ^{levers, (DEADZONE > 0)};
  assign ambiguous   = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ref_code <= '0;
      cnt      <= '0;
      level    <= '0;
    end else begin
      state    <= state_next;
      ref_code <= ref_next;
      cnt      <= cnt_next;
      level    <= level_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    ref_next   = ref_code;
    cnt_next   = cnt;
    level_next = level;
    case (state)
      IDLE: begin
        if (start_game) begin
          state_next = SETTLE;
          ref_next   = candidate;
          cnt_next   = ambiguous ? '0 : CNT_ONE;
        end
      end
      SETTLE: begin
        // game_over wins over every other action taken in SETTLE
        if (game_over) begin
          state_next = IDLE;
        end else if (ambiguous) begin
          cnt_next = '0;
        end else if (candidate != ref_code) begin
          ref_next = candidate;
          cnt_next = CNT_ONE;
        end else if (cnt == CNT_TOP) begin
          level_next = ref_code;
          state_next = LOCKED;
        end else begin
          // The counter stays below CNT_TOP here, so it cannot wrap.
          cnt_next = cnt + CNT_ONE;
        end
      end
      LOCKED: begin
        if (game_over) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy        = (state == SETTLE);
    level_valid = (state == LOCKED);
  end

endmodule

// File: tb/tb_level_selector.sv
// tb_level_selector
//
// Directed stimulus for level_selector (N_LEV=2, DATA_W=16, STABLE_CYCLES=4).
// Each selection that should lock pushes its level and the edge at which the
// lock is due into a scoreboard queue. A monitor pops one entry on every rising
// edge of level_valid and compares it. A lock that nothing expected also counts
// as a mismatch. The stimulus process checks the status outputs directly.

module tb_level_selector;

  localparam int N_LEV  = 2;
  localparam int DATA_W = 16;
  localparam int SC     = 4;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic signed [DATA_W-1:0] ch0 = '0;
  logic signed [DATA_W-1:0] ch1 = '0;
  logic [N_LEV*DATA_W-1:0]  levers;
  logic                     start_game = 1'b0;
  logic                     game_over  = 1'b0;
  logic [N_LEV-1:0]         level;
  logic                     level_valid;
  logic                     busy;

  assign levers = {ch1, ch0};

  level_selector #(
    .N_LEV(N_LEV),
    .DATA_W(DATA_W),
    .STABLE_CYCLES(SC),
    .DEADZONE(2048)
  ) dut (
    .clock(clock),
    .reset(reset),
    .levers(levers),
    .start_game(start_game),
    .game_over(game_over),
    .level(level),
    .level_valid(level_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Number of rising edges seen so far. It is read at negedges.
  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int    lvl;
    int    at_edge;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic void check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endfunction

  // Monitor: a rising edge of level_valid is one lock transaction.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (level_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_lock: got lock of level %0d at edge %0d, required no lock",
                 level, edge_cnt);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_level"}, int'(level), mon_e.lvl);
        check({mon_e.tag, "_lock_edge"}, edge_cnt, mon_e.at_edge);
      end
    end
    prev_valid = level_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Holds start_game high for exactly one edge. k returns that edge's number.
  task automatic pulse_start(output int k);
    k = edge_cnt + 1;
    start_game = 1'b1;
    @(negedge clock);
    start_game = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1;
    @(negedge clock);
    game_over = 1'b0;
  endtask

  task automatic check_status(string tag, int exp_busy, int exp_valid, int exp_level);
    check({tag, "_busy"},  int'(busy),        exp_busy);
    check({tag, "_valid"}, int'(level_valid), exp_valid);
    check({tag, "_level"}, int'(level),       exp_level);
  endtask

  initial begin
    int k;
    int j;

    // Reset state
    tick(3);
    check_status("reset", 0, 0, 0);
    reset = 1'b0;
    tick(3);
    check_status("post_reset_no_start", 0, 0, 0);

    // t1: ch0 negative, ch1 non-negative -> level 1, lock at k+4
    ch0 = -16'sd5000;
    ch1 = 16'sd5000;
    k = edge_cnt + 1;
    sb.push_back('{lvl: 1, at_edge: k + SC, tag: "t1"});
    start_game = 1'b1;
    @(negedge clock);
    start_game = 1'b0;
    for (int i = 0; i < SC; i++) begin
      check("t1_busy_settle", int'(busy), 1);
      check("t1_valid_settle", int'(level_valid), 0);
      @(negedge clock);
    end
    check_status("t1_locked", 0, 1, 1);

    // game_over releases the lock, and level holds its value
    pulse_over();
    check_status("t1_released", 0, 0, 1);

    // t3: candidate 2, then ch1 turns non-negative at edge k+2 -> level 3 at k+6
    ch0 = 16'sd5000;
    ch1 = -16'sd5000;
    k = edge_cnt + 1;
    sb.push_back('{lvl: 3, at_edge: k + 2 + SC, tag: "t3"});
    pulse_start(k);
    @(negedge clock);
    ch1 = 16'sd5000;
    tick(6);
    check_status("t3_locked", 0, 1, 3);

    // t4: while locked, new levers and start_game do not reselect
    ch0 = -16'sd5000;
    ch1 = -16'sd5000;
    pulse_start(k);
    tick(3);
    check_status("t4_no_reselect", 0, 1, 3);
    pulse_over();
    check_status("t4_released", 0, 0, 3);

    // t5: lock level 0, then game_over together with start_game
    k = edge_cnt + 1;
    sb.push_back('{lvl: 0, at_edge: k + SC, tag: "t5a"});
    pulse_start(k);
    tick(SC);
    check_status("t5_locked0", 0, 1, 0);
    ch0 = 16'sd5000;
    ch1 = -16'sd5000;
    j = edge_cnt + 1;
    start_game = 1'b1;
    game_over  = 1'b1;
    @(negedge clock);
    game_over = 1'b0;
    check_status("t5_no_relock_same_edge", 0, 0, 0);
    sb.push_back('{lvl: 2, at_edge: j + 1 + SC, tag: "t5b"});
    @(negedge clock);
    start_game = 1'b0;
    check("t5_restart_busy", int'(busy), 1);
    tick(SC);
    check_status("t5_locked2", 0, 1, 2);
    pulse_over();

    // t6: game_over during SETTLE abandons the selection
    ch0 = -16'sd5000;
    ch1 = 16'sd5000;
    pulse_start(k);
    tick(1);
    check("t6_busy", int'(busy), 1);
    pulse_over();
    check_status("t6_abandoned", 0, 0, 2);
    tick(8);
    check_status("t6_stays_idle", 0, 0, 2);

    // t7: asynchronous reset in the middle of SETTLE
    pulse_start(k);
    tick(1);
    check("t7_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_status("t7_async_reset", 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick(10);
    check_status("t7_no_lock_after_reset", 0, 0, 0);

`ifdef LEVEL_DEADZONE_EN
    // Deadzone: ch0=+1000 is ambiguous, so the design stays in SETTLE
    ch0 = 16'sd1000;
    ch1 = 16'sd5000;
    pulse_start(k);
    tick(10);
    check_status("dz_ambiguous", 1, 0, 0);
    ch0 = 16'sd3000;
    k = edge_cnt + 1;
    sb.push_back('{lvl: 3, at_edge: k + SC, tag: "dz_clear"});
    tick(SC + 1);
    check_status("dz_locked", 0, 1, 3);
    pulse_over();
    // The most negative sample is clearly negative, not ambiguous
    ch0 = -16'sd32768;
    k = edge_cnt + 1;
    sb.push_back('{lvl: 1, at_edge: k + SC, tag: "dz_minneg"});
    pulse_start(k);
    tick(SC);
    check_status("dz_minneg_locked", 0, 1, 1);
    pulse_over();
`endif

    tick(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
